pattern_scan_arbiter: RTL and testbench

Shares one serial "101011" pattern detector between two requesters. Each requester hands over a W-bit parallel frame. The block arbitrates round-robin, serialises the granted frame MSB-first through the detector, and reports how many overlapping occurrences of 101011 the frame contains. It sits between the frame producers and the serial detection datapath and sequences that datapath. Exactly one frame is in flight at a time.

---
 rtl/pattern_scan_arbiter_if.sv | 28 ++
 rtl/pattern_scan_arbiter.sv | 106 ++++++++++
 tb/tb_pattern_scan_arbiter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/pattern_scan_arbiter_if.sv
// Request/grant and result bundle between two frame producers and the shared 101011 scanner.
// Producers drive req/d as the master; the scanner answers on the slave side.
interface pattern_scan_arbiter_if #(
    parameter int W = 8
);
    logic         req0;
    logic         req1;
    logic [W-1:0] d0;
    logic [W-1:0] d1;
    logic         gnt0;
    logic         gnt1;
    logic         busy;
    logic         owner;
    logic         done;
    logic [3:0]   hits;
    logic         found;
    logic [1:0]   state;

    modport master (
        output req0, req1, d0, d1,
        input  gnt0, gnt1, busy, owner, done, hits, found, state
    );

    modport slave (
        input  req0, req1, d0, d1,
        output gnt0, gnt1, busy, owner, done, hits, found, state
    );
endinterface

// File: rtl/pattern_scan_arbiter.sv
// Round-robin shares one serial 101011 matcher between two W-bit frame requesters; accept-to-done is W edges, W+2 per frame.
// No backpressure: requests are levels sampled only in IDLE, so a requester simply holds req until it sees its gnt.
module pattern_scan_arbiter #(
    parameter int W = 8
) (
    input  logic                  ck,
    input  logic                  rs,
    pattern_scan_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] SHIFT = 2'b01;
    localparam logic [1:0] DONE  = 2'b10;

    logic [1:0]   state_q;
    logic [W-1:0] sreg;
    logic [3:0]   bitcnt;
    logic [5:0]   window;
    logic [3:0]   acc;
    logic         last_served;
    logic         owner_q;
    logic         gnt0_q;
    logic         gnt1_q;
    logic         done_q;
    logic         found_q;
    logic [3:0]   hits_q;

    logic         winner;
    logic         shift_bit;
    logic [5:0]   window_nxt;
    logic [3:0]   bitcnt_nxt;
    logic         match;
    logic [3:0]   acc_nxt;
    logic         last_bit;

    always_comb begin
        // On a tie the requester that was not served last wins.
        winner     = (bus.req0 && bus.req1) ? ~last_served : bus.req1;
        shift_bit  = sreg[W-1];
        window_nxt = {window[4:0], shift_bit};
        bitcnt_nxt = bitcnt + 4'd1;
        match      = (bitcnt_nxt >= 4'd6) && (window_nxt == 6'b101011);
        acc_nxt    = acc + {3'b000, match};
        last_bit   = (bitcnt == 4'(W - 1));
    end

    always_ff @(posedge ck or posedge rs) begin
        if (rs) begin
            state_q     <= IDLE;
            sreg        <= '0;
            bitcnt      <= '0;
            window      <= '0;
            acc         <= '0;
            last_served <= 1'b1;
            owner_q     <= 1'b0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            done_q      <= 1'b0;
            found_q     <= 1'b0;
            hits_q      <= '0;
        end else begin
            case (state_q)
                SHIFT: begin
                    gnt0_q <= 1'b0;
                    gnt1_q <= 1'b0;
                    sreg   <= {sreg[W-2:0], 1'b0};
                    window <= window_nxt;
                    bitcnt <= bitcnt_nxt;
                    acc    <= acc_nxt;
                    if (last_bit) begin
                        hits_q  <= acc_nxt;
                        found_q <= (acc_nxt != 4'd0);
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    // Encoding 11 is unused and behaves as IDLE.
                    if (bus.req0 || bus.req1) begin
                        sreg        <= winner ? bus.d1 : bus.d0;
                        owner_q     <= winner;
                        last_served <= winner;
                        gnt0_q      <= ~winner;
                        gnt1_q      <= winner;
                        bitcnt      <= '0;
                        acc         <= '0;
                        window      <= '0;
                        state_q     <= SHIFT;
                    end
                end
            endcase
        end
    end

    assign bus.gnt0  = gnt0_q;
    assign bus.gnt1  = gnt1_q;
    assign bus.busy  = (state_q == SHIFT) || (state_q == DONE);
    assign bus.owner = owner_q;
    assign bus.done  = done_q;
    assign bus.hits  = hits_q;
    assign bus.found = found_q;
    assign bus.state = state_q;
endmodule

// File: tb/tb_pattern_scan_arbiter.sv
// Directed bench for the shared 101011 scanner at W=8 and W=11.
module tb_pattern_scan_arbiter;
    logic ck;
    logic rs;
    int   total;
    int   passes;

    pattern_scan_arbiter_if #(.W(8))  a_if ();
    pattern_scan_arbiter_if #(.W(11)) b_if ();

    pattern_scan_arbiter #(.W(8))  dut_a (.ck(ck), .rs(rs), .bus(a_if.slave));
    pattern_scan_arbiter #(.W(11)) dut_b (.ck(ck), .rs(rs), .bus(b_if.slave));

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic step();
        @(posedge ck);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total = total + 1;
        assert (obs === exp) passes = passes + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One W=8 frame from a single requester; req dropped right after its gnt.
    task automatic run_a(input logic sel, input logic [7:0] data, input logic [3:0] eh);
        if (sel) begin a_if.req1 = 1'b1; a_if.d1 = data; end
        else     begin a_if.req0 = 1'b1; a_if.d0 = data; end
        step();
        chk("a_gnt0_e0", a_if.gnt0, !sel);
        chk("a_gnt1_e0", a_if.gnt1, sel);
        chk("a_busy_e0", a_if.busy, 1);
        chk("a_state_e0", a_if.state, 2'b01);
        chk("a_owner_e0", a_if.owner, sel);
        a_if.req0 = 1'b0;
        a_if.req1 = 1'b0;
        step();
        chk("a_gnt_clr_e1", {a_if.gnt0, a_if.gnt1}, 0);
        repeat (6) step();
        chk("a_done_e7", a_if.done, 0);
        step();
        chk("a_done_e8", a_if.done, 1);
        chk("a_hits_e8", a_if.hits, eh);
        chk("a_found_e8", a_if.found, eh != 0);
        chk("a_state_e8", a_if.state, 2'b10);
        chk("a_owner_e8", a_if.owner, sel);
        step();
        chk("a_done_e9", a_if.done, 0);
        chk("a_state_e9", a_if.state, 2'b00);
        chk("a_busy_e9", a_if.busy, 0);
        chk("a_hits_e9", a_if.hits, eh);
    endtask

    task automatic run_b(input logic [10:0] data, input logic [3:0] eh);
        b_if.req0 = 1'b1;
        b_if.d0   = data;
        step();
        chk("b_gnt0_e0", b_if.gnt0, 1);
        b_if.req0 = 1'b0;
        repeat (10) step();
        chk("b_done_e10", b_if.done, 0);
        step();
        chk("b_done_e11", b_if.done, 1);
        chk("b_hits_e11", b_if.hits, eh);
        chk("b_found_e11", b_if.found, eh != 0);
        step();
        chk("b_state_e12", b_if.state, 2'b00);
    endtask

    initial begin
        total  = 0;
        passes = 0;
        rs = 1'b1;
        a_if.req0 = 1'b0; a_if.req1 = 1'b0; a_if.d0 = '0; a_if.d1 = '0;
        b_if.req0 = 1'b0; b_if.req1 = 1'b0; b_if.d0 = '0; b_if.d1 = '0;
        repeat (2) step();
        chk("rst_state", a_if.state, 2'b00);
        chk("rst_gnt", {a_if.gnt0, a_if.gnt1}, 0);
        chk("rst_busy", a_if.busy, 0);
        chk("rst_owner", a_if.owner, 0);
        chk("rst_done", a_if.done, 0);
        chk("rst_hits", a_if.hits, 0);
        chk("rst_found", a_if.found, 0);
        rs = 1'b0;
        step();

        run_a(1'b0, 8'b10101100, 4'd1);
        run_a(1'b1, 8'b10101011, 4'd1);

        // Reset in the middle of a frame: outputs clear without a clock edge, no done.
        a_if.req0 = 1'b1; a_if.d0 = 8'b10101100;
        step();
        a_if.req0 = 1'b0;
        repeat (4) step();
        rs = 1'b1;
        #1;
        chk("arst_state", a_if.state, 2'b00);
        chk("arst_busy", a_if.busy, 0);
        chk("arst_hits", a_if.hits, 0);
        chk("arst_found", a_if.found, 0);
        chk("arst_owner", a_if.owner, 0);
        chk("arst_done", a_if.done, 0);
        repeat (6) begin
            step();
            chk("arst_no_done", a_if.done, 0);
        end
        rs = 1'b0;
        step();
        run_a(1'b1, 8'b10101100, 4'd1);
        run_a(1'b1, 8'h00, 4'd0);

        // After a reset, both requesters held high alternate 0,1,0,1 every W+2 edges.
        rs = 1'b1;
        step();
        rs = 1'b0;
        step();
        a_if.req0 = 1'b1; a_if.d0 = 8'b10101100;
        a_if.req1 = 1'b1; a_if.d1 = 8'h00;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("rr_gnt0", a_if.gnt0, (k % 2) == 0);
            chk("rr_gnt1", a_if.gnt1, (k % 2) == 1);
            if (k == 3) begin
                a_if.req0 = 1'b0;
                a_if.req1 = 1'b0;
            end
            for (int c = 0; c < 9; c++) begin
                step();
                chk("rr_excl", a_if.gnt0 & a_if.gnt1, 0);
                if (c == 7) chk("rr_done", a_if.done, 1);
            end
        end
        chk("rr_last_hits", a_if.hits, 0);

        // A request raised during DONE waits for the IDLE edge.
        a_if.req0 = 1'b1; a_if.d0 = 8'b10101100;
        step();
        chk("gl_gnt0", a_if.gnt0, 1);
        a_if.req0 = 1'b0;
        repeat (8) step();
        chk("gl_done", a_if.done, 1);
        chk("gl_hits", a_if.hits, 1);
        a_if.req1 = 1'b1; a_if.d1 = 8'h00;
        step();
        chk("gl_no_gnt_done", a_if.gnt1, 0);
        chk("gl_idle", a_if.state, 2'b00);
        chk("gl_hits_hold", a_if.hits, 1);
        step();
        chk("gl_gnt1", a_if.gnt1, 1);
        a_if.req1 = 1'b0;
        repeat (5) step();
        chk("gl_hits_mid", a_if.hits, 1);
        repeat (3) step();
        chk("gl_done2", a_if.done, 1);
        chk("gl_hits2", a_if.hits, 0);
        chk("gl_found2", a_if.found, 0);
        chk("gl_owner2", a_if.owner, 1);
        step();

        run_b(11'b10101101011, 4'd2);
        run_b(11'b10101110101, 4'd1);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
